fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the FIFO write port; legal range 2..8.
REQ-002 Parameter DATA_W, default 8: width of the data word, matching the FIFO buf_in width.
REQ-003 Parameter MAX_BURST, default 8: maximum words accepted per grant before forced release; legal range 1..255.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  N_REQ  per-requester word-valid.
REQ-007 req_data  input  N_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 req_last  input  N_REQ  marks the final word of requester i's packet; qualified by req_valid[i].
REQ-009 req_ready  output  N_REQ  per-requester accept; a word transfers when req_valid[i] and req_ready[i] are both high.
REQ-010 fifo_full  input  1  FIFO buf_full.
REQ-011 fifo_wr_en  output  1  FIFO write enable.
REQ-012 fifo_din  output  DATA_W  FIFO write data.
REQ-013 grant  output  N_REQ  one-hot registered grant; all zero when no requester holds the port.
REQ-014 grant_id  output  clog2(N_REQ)  binary index of the current or most recent grantee.
REQ-015 busy  output  1  high while in LOCK.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and LOCK.
REQ-017 In IDLE with any req_valid high, the block SHALL select the first requester with valid set, searching from (grant_id+1) mod N_REQ upward with wrap.
REQ-018 The selection SHALL register into grant and grant_id, with transition to LOCK at the next edge; IDLE with no valid SHALL stay IDLE with grant zero.
REQ-019 In LOCK, req_ready[g] SHALL equal !fifo_full combinationally for grantee g; all other req_ready bits SHALL be 0.
REQ-020 req_ready SHALL be all zero in IDLE.
REQ-021 fifo_wr_en SHALL equal req_valid[g] && req_ready[g] combinationally.
REQ-022 fifo_din SHALL equal req_data of grantee g whenever grant is nonzero, and 0 otherwise.
REQ-023 A burst counter SHALL clear on entry to LOCK and increment by 1 on each transfer.
REQ-024 LOCK SHALL exit to IDLE, with grant cleared, at the edge of a transfer where req_last[g] is high.
REQ-025 LOCK SHALL also exit to IDLE, with grant cleared, at the edge of the transfer that makes the burst count equal MAX_BURST (forced release).
REQ-026 grant_id SHALL hold its value through IDLE so round-robin resumes after the last grantee.
REQ-027 A grant cycle SHALL cost exactly one IDLE arbitration cycle between bursts, with no back-to-back LOCK without IDLE.
REQ-028 With fifo_full high in LOCK, no transfer SHALL occur and state and counter SHALL hold; deasserting full SHALL resume on the same cycle.
REQ-029 With req_valid[g] low in LOCK, the grant SHALL be held with no timeout.
REQ-030 A force-released requester with words remaining SHALL re-arbitrate normally and receive no priority boost.
REQ-031 With MAX_BURST=1, every grant SHALL transfer exactly one word.
REQ-032 The block SHALL never issue fifo_wr_en while fifo_full is high.

Reset
REQ-033 On rst, the FSM SHALL enter IDLE asynchronously.
REQ-034 On rst, grant SHALL be 0, busy 0, and the burst counter 0.
REQ-035 On rst, grant_id SHALL be N_REQ-1 so that requester 0 has first priority.
REQ-036 Combinational outputs SHALL follow from the reset state: req_ready=0, fifo_wr_en=0, fifo_din=0.
REQ-037 Reset asserted mid-burst SHALL abandon the burst immediately, with no fifo_wr_en in that cycle.

Verification
REQ-038 Single packet: after reset, req_valid=0001, 3 words 0x11,0x22,0x33 with last on 0x33 -> grant=0001 one cycle later, 3 consecutive fifo_wr_en with din 0x11,0x22,0x33, then IDLE, grant=0.
REQ-039 Round-robin: all four requesters continuously valid with 1-word packets -> grant order 0,1,2,3,0, each separated by one IDLE cycle.
REQ-040 Forced release: MAX_BURST=8, requester 2 streams 12 words with no last, requester 1 idle -> 8 writes, IDLE, grant 2 again, 4 writes.
REQ-041 Full backpressure: fifo_full held high for 5 cycles mid-burst after word 2 -> fifo_wr_en=0 and req_ready=0 for those 5 cycles, burst count stays 2, burst resumes on the cycle full drops.
REQ-042 Reset mid-burst: rst asserted during the 3rd word of requester 1 -> outputs zero immediately; after release, requester 0 wins if valid.
REQ-043 Fairness: requester 3 holding valid while 0..2 flood traffic -> requester 3 granted within N_REQ arbitration cycles.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets N_REQ packet sources share one FIFO write port,
// holding the grant for a whole packet or until MAX_BURST words have been written.

module fifo_wr_arbiter_lane #(
    parameter int DATA_W = 8
) (
    input  logic              gnt,
    input  logic              fifo_full,
    input  logic              valid,
    input  logic              last,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              wr,
    output logic              wr_last,
    output logic [DATA_W-1:0] din
);
    assign ready   = gnt & ~fifo_full;
    assign wr      = valid & ready;
    assign wr_last = wr & last;
    assign din     = gnt ? data : '0;
endmodule

module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_wr_en,
    output logic [DATA_W-1:0]        fifo_din,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t                         state;
    logic [CNT_W-1:0]               burst_cnt;
    logic [N_REQ-1:0]               wr_vec;
    logic [N_REQ-1:0]               wr_last_vec;
    logic [N_REQ-1:0][DATA_W-1:0]   lane_din;
    logic                           xfer_last;
    logic                           burst_done;
    logic                           sel_found;
    logic [ID_W-1:0]                sel_id;
    logic [N_REQ-1:0]               sel_oh;

    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
        fifo_wr_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
            .gnt       (grant[g]),
            .fifo_full (fifo_full),
            .valid     (req_valid[g]),
            .last      (req_last[g]),
            .data      (req_data[g*DATA_W +: DATA_W]),
            .ready     (req_ready[g]),
            .wr        (wr_vec[g]),
            .wr_last   (wr_last_vec[g]),
            .din       (lane_din[g])
        );
    end

    // grant is one-hot, so OR-ing the masked lane data selects the grantee
    always_comb begin
        fifo_din = '0;
        for (int i = 0; i < N_REQ; i++)
            fifo_din = fifo_din | lane_din[i];
    end

    assign fifo_wr_en = |wr_vec;
    assign xfer_last  = |wr_last_vec;
    assign burst_done = (burst_cnt == CNT_W'(MAX_BURST - 1));

    // First valid requester after the most recent grantee, wrapping around
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        sel_oh    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!sel_found && req_valid[(int'(grant_id) + k) % N_REQ]) begin
                sel_found = 1'b1;
                sel_id    = ID_W'((int'(grant_id) + k) % N_REQ);
                sel_oh[(int'(grant_id) + k) % N_REQ] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            grant_id  <= ID_W'(N_REQ - 1);
            burst_cnt <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        state     <= LOCK;
                        grant     <= sel_oh;
                        grant_id  <= sel_id;
                        burst_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                LOCK: begin
                    if (fifo_wr_en) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        if (xfer_last || burst_done) begin
                            state <= IDLE;
                            grant <= '0;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester queues feed the DUT while a
// monitor checks every FIFO write and new grant against scoreboard queues.

module tb_fifo_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_din;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic        busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_BURST(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .grant      (grant),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    int         total = 0;
    int         bad   = 0;
    logic [8:0] rq [4][$];      // {last, data} per requester
    logic [9:0] exp_wr[$];      // {grant_id, data}
    logic [3:0] exp_gnt[$];
    logic [3:0] hs;
    int         nxfer[4];
    int         full_left;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    function automatic bit queues_empty();
        return rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 && rq[3].size() == 0;
    endfunction

    task automatic clear();
        for (int i = 0; i < 4; i++) begin
            rq[i].delete();
            nxfer[i] = 0;
        end
        hs        = '0;
        full_left = 0;
        fifo_full = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
    endtask

    // One cycle: retire last cycle's handshakes, drive new heads, note new handshakes
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            if (hs[i]) rq[i].delete(0);
        if (full_left > 0) begin
            fifo_full = 1'b1;
            full_left--;
        end else begin
            fifo_full = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            req_valid[i]       = rq[i].size() > 0;
            req_data[i*8 +: 8] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
            req_last[i]        = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
        end
        #1;
        hs = req_valid & req_ready;
        for (int i = 0; i < 4; i++)
            if (hs[i]) nxfer[i]++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear();
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 3);
        chk("rst_burst_cnt", dut.burst_cnt, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_din", fifo_din, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n = 0;
        bit done = 0;
        while (!done && n < limit) begin
            step();
            n++;
            done = queues_empty() && grant == 4'b0000;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got not-drained want drained within %0d cycles", name, limit);
        end
    endtask

    // Monitor: scoreboard pops plus per-cycle protocol invariants
    initial begin
        logic [3:0] prev_g;
        logic       prev_idle_v;
        prev_g      = '0;
        prev_idle_v = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_g      = '0;
                prev_idle_v = 1'b0;
            end else begin
                chk("busy_vs_grant", busy, grant != 4'b0000);
                if (grant == 4'b0000) chk("din_idle", fifo_din, 0);
                if (fifo_full) begin
                    chk("wr_when_full", fifo_wr_en, 0);
                    chk("ready_when_full", req_ready, 0);
                end
                if (prev_idle_v) chk("arb_one_cycle", grant != 4'b0000, 1);
                if (prev_g != 4'b0000 && grant != 4'b0000) chk("no_b2b_lock", grant, prev_g);
                if (grant != 4'b0000 && prev_g == 4'b0000) begin
                    if (exp_gnt.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexp_grant: got %0h want none", grant);
                    end else begin
                        chk("grant_order", grant, exp_gnt.pop_front());
                    end
                end
                if (fifo_wr_en) begin
                    if (exp_wr.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexp_write: got id=%0d din=%0h want none", grant_id, fifo_din);
                    end else begin
                        chk("write", {grant_id, fifo_din}, exp_wr.pop_front());
                    end
                end
                prev_g      = grant;
                prev_idle_v = (grant == 4'b0000) && (req_valid != 4'b0000);
            end
        end
    end

    initial begin
        bit pushed3, got3, was_g, seen_rel;
        int arb;
        rst = 1'b1;
        clear();

        // Single 3-word packet from requester 0
        do_reset();
        rq[0].push_back({1'b0, 8'h11});
        rq[0].push_back({1'b0, 8'h22});
        rq[0].push_back({1'b1, 8'h33});
        exp_gnt.push_back(4'b0001);
        exp_wr.push_back({2'd0, 8'h11});
        exp_wr.push_back({2'd0, 8'h22});
        exp_wr.push_back({2'd0, 8'h33});
        step(); chk("t1_idle_first", grant, 0);
        step(); chk("t1_grant_lat", grant, 4'b0001); chk("t1_wr1", fifo_wr_en, 1);
        step(); chk("t1_wr2", fifo_wr_en, 1);
        step(); chk("t1_wr3", fifo_wr_en, 1);
        step(); chk("t1_end_grant", grant, 0); chk("t1_gid", grant_id, 0);

        // Round-robin over four always-valid requesters, 1-word packets
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rq[i].push_back({1'b1, 8'hA0 + 8'(i)});
            rq[i].push_back({1'b1, 8'hB0 + 8'(i)});
        end
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) begin
                exp_gnt.push_back(4'b0001 << i);
                exp_wr.push_back({2'(i), (k == 0 ? 8'hA0 : 8'hB0) + 8'(i)});
            end
        wait_done("t2", 60);
        chk("t2_gid", grant_id, 3);

        // Forced release after 8 words, then re-grant of the same requester
        do_reset();
        for (int w = 0; w < 12; w++) begin
            rq[2].push_back({1'b0, 8'hC0 + 8'(w)});
            exp_wr.push_back({2'd2, 8'hC0 + 8'(w)});
        end
        exp_gnt.push_back(4'b0100);
        exp_gnt.push_back(4'b0100);
        was_g = 0; seen_rel = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (grant != 4'b0000) was_g = 1;
            else if (was_g && !seen_rel) begin
                seen_rel = 1;
                chk("t3_release_at", nxfer[2], 8);
            end
            if (rq[2].size() == 0) break;
        end
        chk("t3_drain", rq[2].size(), 0);
        chk("t3_release_seen", seen_rel, 1);
        repeat (5) step();
        chk("t3_hold_grant", grant, 4'b0100);
        chk("t3_hold_busy", busy, 1);
        chk("t3_burst_cnt", dut.burst_cnt, 4);

        // FIFO full for 5 cycles after the 2nd word
        do_reset();
        for (int w = 0; w < 5; w++) begin
            rq[1].push_back({w == 4, 8'hD0 + 8'(w)});
            exp_wr.push_back({2'd1, 8'hD0 + 8'(w)});
        end
        exp_gnt.push_back(4'b0010);
        for (int c = 0; c < 20 && nxfer[1] < 2; c++) step();
        chk("t4_two_words", nxfer[1], 2);
        full_left = 5;
        repeat (5) begin
            step();
            chk("t4_cnt_hold", dut.burst_cnt, 2);
            chk("t4_ready_low", req_ready, 0);
            chk("t4_wr_low", fifo_wr_en, 0);
        end
        step();
        chk("t4_resume", fifo_wr_en, 1);
        wait_done("t4", 20);

        // Reset in the cycle of requester 1's 3rd word
        do_reset();
        for (int w = 0; w < 5; w++)
            rq[1].push_back({w == 4, 8'hE0 + 8'(w)});
        exp_gnt.push_back(4'b0010);
        exp_wr.push_back({2'd1, 8'hE0});
        exp_wr.push_back({2'd1, 8'hE1});
        for (int c = 0; c < 20 && nxfer[1] < 3; c++) step();
        chk("t5_third_pending", fifo_wr_en, 1);
        rst = 1'b1;
        #1;
        chk("t5_grant", grant, 0);
        chk("t5_wr_en", fifo_wr_en, 0);
        chk("t5_ready", req_ready, 0);
        chk("t5_din", fifo_din, 0);
        chk("t5_busy", busy, 0);
        clear();
        @(negedge clk);
        rst = 1'b0;
        rq[0].push_back({1'b1, 8'hF0});
        rq[1].push_back({1'b1, 8'hF1});
        exp_gnt.push_back(4'b0001);
        exp_gnt.push_back(4'b0010);
        exp_wr.push_back({2'd0, 8'hF0});
        exp_wr.push_back({2'd1, 8'hF1});
        wait_done("t5", 20);

        // Fairness: requester 3 arrives while 0..2 flood
        do_reset();
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 3; i++)
                rq[i].push_back({1'b1, 8'(16 * (k + 1) + i)});
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 3; i++) begin
                exp_gnt.push_back(4'b0001 << i);
                exp_wr.push_back({2'(i), 8'(16 * (k + 1) + i)});
            end
            if (k == 0) begin
                exp_gnt.push_back(4'b1000);
                exp_wr.push_back({2'd3, 8'hF3});
            end
        end
        pushed3 = 0; got3 = 0; arb = 0;
        for (int c = 0; c < 80; c++) begin
            step();
            if (pushed3 && !got3) begin
                if (grant == 4'b0000) arb++;
                if (grant[3]) got3 = 1;
            end
            if (!pushed3 && grant == 4'b0010) begin
                rq[3].push_back({1'b1, 8'hF3});
                pushed3 = 1;
            end
            if (pushed3 && queues_empty() && grant == 4'b0000) break;
        end
        chk("t6_got3", got3, 1);
        chk("t6_arb_cycles", arb, 2);
        chk("t6_drain", queues_empty(), 1);

        step();
        chk("leftover_wr", exp_wr.size(), 0);
        chk("leftover_gnt", exp_gnt.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
